cpu_sram_axi_bridge: RTL and testbench

Converts the CPU core's two request/acknowledge SRAM-style ports (instruction fetch, data access) into a single AXI master channel set. It sits directly downstream of the CPU top, between the core's memory ports and the AXI interconnect or memory model. The bridge serves one transaction at a time, gives data accesses priority over fetches, and returns one registered `data_ok` pulse per accepted request.

---
 rtl/cpu_sram_axi_bridge.sv | 204 ++++++++++++++++++++
 tb/tb_cpu_sram_axi_bridge.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sram_axi_bridge.sv
// Bridges the CPU's instruction-fetch and data SRAM-style ports onto one AXI master.
// One transaction in flight at a time; a fixed priority picks between simultaneous requests.
module cpu_sram_axi_bridge #(
    parameter int DATA_PRIO = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic [70:0] data_req_bus,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic [31:0] rdata,

    output logic [35:0] ar_bus,
    output logic        arvalid,
    input  logic        arready,

    input  logic [31:0] r_data,
    input  logic        rvalid,
    output logic        rready,

    output logic [34:0] aw_bus,
    output logic        awvalid,
    input  logic        awready,

    output logic [35:0] w_bus,
    output logic        wvalid,
    input  logic        wready,

    input  logic        bvalid,
    output logic        bready
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] S_AW   = 3'd3;
    localparam logic [2:0] S_B    = 3'd4;

    logic [2:0]  state_q, state_d;
    logic        owner_q, owner_d;       // 1 = data port, 0 = inst port
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        inst_ok_q, inst_ok_d;
    logic        data_ok_q, data_ok_d;
    logic [31:0] rdata_q, rdata_d;

    logic        req_wr;
    logic [1:0]  req_size;
    logic [3:0]  req_wstrb;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        idle_open;
    logic        data_wins;
    logic        inst_wins;
    logic        aw_hs;
    logic        w_hs;

    assign req_wr    = data_req_bus[70];
    assign req_size  = data_req_bus[69:68];
    assign req_wstrb = data_req_bus[67:64];
    assign req_addr  = data_req_bus[63:32];
    assign req_wdata = data_req_bus[31:0];

    // Grant is only offered in IDLE and never while reset is held.
    assign idle_open = (state_q == S_IDLE) && !rst;
    assign data_wins = data_req && ((DATA_PRIO != 0) || !inst_req);
    assign inst_wins = inst_req && ((DATA_PRIO == 0) || !data_req);

    assign data_addr_ok = idle_open && data_wins;
    assign inst_addr_ok = idle_open && inst_wins;

    assign arvalid = (state_q == S_AR);
    assign rready  = (state_q == S_R);
    assign awvalid = (state_q == S_AW) && !aw_done_q;
    assign wvalid  = (state_q == S_AW) && !w_done_q;
    assign bready  = (state_q == S_B);

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    // Channel payloads come straight from the captured request so they hold while valid is up.
    assign ar_bus = {owner_q, 1'b0, size_q, addr_q};
    assign aw_bus = {1'b0, size_q, addr_q};
    assign w_bus  = {wstrb_q, wdata_q};

    assign inst_data_ok = inst_ok_q;
    assign data_data_ok = data_ok_q;
    assign rdata        = rdata_q;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        wr_d      = wr_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wstrb_d   = wstrb_q;
        wdata_d   = wdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        inst_ok_d = 1'b0;
        data_ok_d = 1'b0;
        rdata_d   = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (data_addr_ok) begin
                    owner_d = 1'b1;
                    wr_d    = req_wr;
                    size_d  = req_size;
                    addr_d  = req_addr;
                    wstrb_d = req_wstrb;
                    wdata_d = req_wdata;
                    state_d = req_wr ? S_AW : S_AR;
                end else if (inst_addr_ok) begin
                    owner_d = 1'b0;
                    wr_d    = 1'b0;
                    size_d  = 2'b10;
                    addr_d  = inst_addr;
                    wstrb_d = 4'b0000;
                    wdata_d = 32'h0;
                    state_d = S_AR;
                end
            end
            S_AR: begin
                if (arready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                if (rvalid) begin
                    rdata_d   = r_data;
                    inst_ok_d = !owner_q;
                    data_ok_d = owner_q;
                    state_d   = S_IDLE;
                end
            end
            S_AW: begin
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                // Address and data may complete in either order or together.
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_B;
                end
            end
            S_B: begin
                if (bvalid) begin
                    inst_ok_d = !owner_q;
                    data_ok_d = owner_q;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            wr_q      <= 1'b0;
            size_q    <= 2'b00;
            addr_q    <= 32'h0;
            wstrb_q   <= 4'b0000;
            wdata_q   <= 32'h0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            inst_ok_q <= 1'b0;
            data_ok_q <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            wr_q      <= wr_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wstrb_q   <= wstrb_d;
            wdata_q   <= wdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            inst_ok_q <= inst_ok_d;
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_cpu_sram_axi_bridge.sv
// Directed bench for cpu_sram_axi_bridge: zero-wait transaction table plus hand-written corner sequences.
module tb_cpu_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic        data_req;
    logic [70:0] data_req_bus;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] rdata;
    logic [35:0] ar_bus;
    logic        arvalid;
    logic        arready;
    logic [31:0] r_data;
    logic        rvalid;
    logic        rready;
    logic [34:0] aw_bus;
    logic        awvalid;
    logic        awready;
    logic [35:0] w_bus;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    int n_vec = 0;
    int n_err = 0;

    cpu_sram_axi_bridge #(.DATA_PRIO(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .data_req     (data_req),
        .data_req_bus (data_req_bus),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .rdata        (rdata),
        .ar_bus       (ar_bus),
        .arvalid      (arvalid),
        .arready      (arready),
        .r_data       (r_data),
        .rvalid       (rvalid),
        .rready       (rready),
        .aw_bus       (aw_bus),
        .awvalid      (awvalid),
        .awready      (awready),
        .w_bus        (w_bus),
        .wvalid       (wvalid),
        .wready       (wready),
        .bvalid       (bvalid),
        .bready       (bready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_data;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] resp;
        logic [35:0] exp_ar;
        logic [34:0] exp_aw;
        logic [35:0] exp_w;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance into the next cycle; inputs are then set and given 1ns to settle before checks.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        inst_req     = 1'b0;
        data_req     = 1'b0;
        arready      = 1'b0;
        rvalid       = 1'b0;
        awready      = 1'b0;
        wready       = 1'b0;
        bvalid       = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        step();
        if (v.is_data) begin
            data_req     = 1'b1;
            data_req_bus = {v.wr, v.size, v.wstrb, v.addr, v.wdata};
        end else begin
            inst_req  = 1'b1;
            inst_addr = v.addr;
        end
        settle();
        chk("addr_ok", {62'd0, inst_addr_ok, data_addr_ok}, v.is_data ? 64'd1 : 64'd2);

        step();
        clear_inputs();
        if (v.wr) begin
            awready = 1'b1;
            wready  = 1'b1;
        end else begin
            arready = 1'b1;
        end
        settle();
        if (v.wr) begin
            chk("aw_w_valid", {62'd0, awvalid, wvalid}, 64'd3);
            chk("aw_bus", {29'd0, aw_bus}, {29'd0, v.exp_aw});
            chk("w_bus", {28'd0, w_bus}, {28'd0, v.exp_w});
        end else begin
            chk("arvalid", {63'd0, arvalid}, 64'd1);
            chk("ar_bus", {28'd0, ar_bus}, {28'd0, v.exp_ar});
        end

        step();
        clear_inputs();
        if (v.wr) begin
            bvalid = 1'b1;
        end else begin
            rvalid = 1'b1;
            r_data = v.resp;
        end
        settle();
        chk(v.wr ? "bready" : "rready", {63'd0, v.wr ? bready : rready}, 64'd1);

        step();
        clear_inputs();
        settle();
        chk("data_ok_pulse", {62'd0, inst_data_ok, data_data_ok}, v.is_data ? 64'd1 : 64'd2);
        chk("rdata", {32'd0, rdata}, {32'd0, v.exp_rdata});

        step();
        settle();
        chk("data_ok_clear", {62'd0, inst_data_ok, data_data_ok}, 64'd0);
        $display("txn %0d: data=%0b wr=%0b addr=%h done", idx, v.is_data, v.wr, v.addr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b0, 1'b0, 2'b10, 4'h0, 32'h1c000000, 32'h0, 32'h02800c0c,
                   36'h2_1c000000, 35'h0, 36'h0, 32'h02800c0c};
        tbl[1] = '{1'b1, 1'b0, 2'b10, 4'h0, 32'h1c008000, 32'h0, 32'h12345678,
                   36'hA_1c008000, 35'h0, 36'h0, 32'h12345678};
        tbl[2] = '{1'b1, 1'b0, 2'b00, 4'h0, 32'h1c008003, 32'h0, 32'hdeadbeef,
                   36'h8_1c008003, 35'h0, 36'h0, 32'hdeadbeef};
        tbl[3] = '{1'b1, 1'b1, 2'b10, 4'hF, 32'h1c00800c, 32'hcafef00d, 32'h0,
                   36'h0, 35'h2_1c00800c, 36'hF_cafef00d, 32'hdeadbeef};
        tbl[4] = '{1'b1, 1'b1, 2'b01, 4'hC, 32'h1c008012, 32'h55660000, 32'h0,
                   36'h0, 35'h1_1c008012, 36'hC_55660000, 32'hdeadbeef};
        tbl[5] = '{1'b0, 1'b0, 2'b10, 4'h0, 32'h1c000004, 32'h0, 32'h00000013,
                   36'h2_1c000004, 35'h0, 36'h0, 32'h00000013};

        clear_inputs();
        rst          = 1'b1;
        inst_req     = 1'b1;
        inst_addr    = 32'h1c000000;
        data_req_bus = '0;
        r_data       = '0;

        // Reset held for three cycles with a pending fetch.
        for (int i = 0; i < 3; i++) begin
            step();
            settle();
            chk("rst_ctl", {55'd0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok,
                            arvalid, rready, awvalid, wvalid, bready}, 64'd0);
            chk("rst_rdata", {32'd0, rdata}, 64'd0);
            chk("rst_ar_bus", {28'd0, ar_bus}, 64'd0);
            chk("rst_aw_bus", {29'd0, aw_bus}, 64'd0);
            chk("rst_w_bus", {28'd0, w_bus}, 64'd0);
        end
        step();
        rst = 1'b0;
        settle();
        chk("post_rst_inst_addr_ok", {63'd0, inst_addr_ok}, 64'd1);
        inst_req = 1'b0;
        $display("txn reset: done");

        for (int i = 0; i < 6; i++) begin
            run_vec(i, tbl[i]);
        end

        // Simultaneous requests: data wins, fetch is accepted on the data_ok cycle.
        step();
        inst_req     = 1'b1;
        inst_addr    = 32'h1c000010;
        data_req     = 1'b1;
        data_req_bus = {1'b0, 2'b10, 4'h0, 32'h1c008000, 32'h0};
        settle();
        chk("prio_addr_ok", {62'd0, inst_addr_ok, data_addr_ok}, 64'd1);
        step();
        data_req = 1'b0;
        arready  = 1'b1;
        settle();
        chk("prio_arid", {62'd0, arvalid, ar_bus[35]}, 64'd3);
        chk("prio_inst_wait", {62'd0, inst_addr_ok, data_addr_ok}, 64'd0);
        step();
        arready = 1'b0;
        rvalid  = 1'b1;
        r_data  = 32'ha5a5a5a5;
        settle();
        chk("prio_rready", {63'd0, rready}, 64'd1);
        step();
        rvalid = 1'b0;
        settle();
        chk("prio_data_ok", {62'd0, inst_data_ok, data_data_ok}, 64'd1);
        chk("prio_inst_accept", {63'd0, inst_addr_ok}, 64'd1);
        chk("prio_rdata", {32'd0, rdata}, {32'd0, 32'ha5a5a5a5});
        step();
        inst_req = 1'b0;
        arready  = 1'b1;
        settle();
        chk("prio_inst_ar", {27'd0, arvalid, ar_bus}, {27'd0, 1'b1, 36'h2_1c000010});
        step();
        arready = 1'b0;
        rvalid  = 1'b1;
        r_data  = 32'h11111111;
        settle();
        step();
        rvalid = 1'b0;
        settle();
        chk("prio_inst_ok", {62'd0, inst_data_ok, data_data_ok}, 64'd2);
        chk("prio_inst_rdata", {32'd0, rdata}, {32'd0, 32'h11111111});
        $display("txn priority: done");

        // Byte store, awready in cycle 1, wready only in cycle 3, bvalid in cycle 5.
        step();
        data_req     = 1'b1;
        data_req_bus = {1'b1, 2'b00, 4'b0100, 32'h1c008002, 32'h00ab0000};
        settle();
        chk("st_addr_ok", {63'd0, data_addr_ok}, 64'd1);
        step();
        data_req = 1'b0;
        awready  = 1'b1;
        settle();
        chk("st_c1_valid", {62'd0, awvalid, wvalid}, 64'd3);
        chk("st_aw_bus", {29'd0, aw_bus}, {29'd0, 35'h0_1c008002});
        chk("st_w_bus", {28'd0, w_bus}, {28'd0, 36'h4_00ab0000});
        step();
        awready = 1'b0;
        settle();
        chk("st_c2_valid", {61'd0, awvalid, wvalid, bready}, 64'd2);
        step();
        wready = 1'b1;
        settle();
        chk("st_c3_valid", {61'd0, awvalid, wvalid, bready}, 64'd2);
        step();
        wready = 1'b0;
        settle();
        chk("st_c4_bready", {60'd0, awvalid, wvalid, bready, data_data_ok}, 64'd2);
        step();
        bvalid = 1'b1;
        settle();
        chk("st_c5_bready", {63'd0, bready}, 64'd1);
        chk("st_c5_no_ok", {63'd0, data_data_ok}, 64'd0);
        step();
        bvalid = 1'b0;
        settle();
        chk("st_data_ok", {61'd0, data_data_ok, bready, wvalid}, 64'd4);
        $display("txn delayed store: done");

        // Address stall: arready low for five cycles while both ports keep requesting.
        step();
        inst_req  = 1'b1;
        inst_addr = 32'h1c000020;
        settle();
        chk("stall_addr_ok", {63'd0, inst_addr_ok}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            inst_addr    = 32'h1c000040;
            data_req     = 1'b1;
            data_req_bus = {1'b0, 2'b10, 4'h0, 32'h1c009000, 32'h0};
            settle();
            chk("stall_ar", {27'd0, arvalid, ar_bus}, {27'd0, 1'b1, 36'h2_1c000020});
            chk("stall_no_addr_ok", {62'd0, inst_addr_ok, data_addr_ok}, 64'd0);
        end
        step();
        clear_inputs();
        arready = 1'b1;
        settle();
        chk("stall_release", {27'd0, arvalid, ar_bus}, {27'd0, 1'b1, 36'h2_1c000020});
        step();
        arready = 1'b0;
        rvalid  = 1'b1;
        r_data  = 32'h0badf00d;
        settle();
        step();
        rvalid = 1'b0;
        settle();
        chk("stall_ok", {62'd0, inst_data_ok, data_data_ok}, 64'd2);
        chk("stall_rdata", {32'd0, rdata}, {32'd0, 32'h0badf00d});
        $display("txn ar stall: done");

        // Reset while waiting for read data; the late rvalid must be ignored.
        step();
        inst_req  = 1'b1;
        inst_addr = 32'h1c000030;
        settle();
        step();
        inst_req = 1'b0;
        arready  = 1'b1;
        settle();
        step();
        arready = 1'b0;
        settle();
        chk("rstR_in_R", {63'd0, rready}, 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        chk("rstR_after", {60'd0, rready, arvalid, inst_data_ok, data_data_ok}, 64'd0);
        chk("rstR_ar_bus", {28'd0, ar_bus}, 64'd0);
        step();
        rvalid = 1'b1;
        r_data = 32'hffffffff;
        settle();
        chk("rstR_late_rvalid", {63'd0, rready}, 64'd0);
        step();
        rvalid = 1'b0;
        settle();
        chk("rstR_no_ok", {62'd0, inst_data_ok, data_data_ok}, 64'd0);
        chk("rstR_rdata", {32'd0, rdata}, 64'd0);
        $display("txn reset in R: done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
